// File: rtl/mux_arbiter_2to1.sv
// mux_arbiter_2to1: two-requester round-robin arbiter driving a shared
// WIDTH-bit 2:1 select path into a one-word output register.
//
// Optional feature macro: ARB_LOCK_EN
//   defined   : 'lock' pins the grant to the current owner (owner flag).
//   undefined : 'lock' is ignored; pure round-robin.
//
// Handshakes:
//   Input side  : reqX=1 offers dataX; ackX=1 (combinational) means the word
//                 is taken at the coming rising edge. The requester holds
//                 reqX/dataX stable until it sees ackX, then may drop/change.
//   Output side : out_valid=1 means out_data/out_src hold an undelivered
//                 word; it is consumed at an edge where out_valid & out_ready.
//                 While out_valid & ~out_ready the word is held stable.
module mux_arbiter_2to1 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  input  logic             lock,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
  output logic             o_dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_space;
  logic             w_elig0;
  logic             w_elig1;
  logic             w_accept;
  logic             w_winner;

`ifdef ARB_LOCK_EN
  logic             r_owner;

  // While the owner flag is set only the last winner may be granted.
  always_comb begin
    w_elig0 = req0 & (~r_owner | (r_last == 1'b0));
    w_elig1 = req1 & (~r_owner | (r_last == 1'b1));
  end

  // Owner flag follows 'lock' as sampled on each accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= 1'b0;
    end else if (w_accept) begin
      r_owner <= lock;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = lock;

  // Without locking, any asserted request is eligible.
  always_comb begin
    w_elig0 = req0;
    w_elig1 = req1;
  end
`endif

  // Space exists when the output register is empty or is being drained now;
  // a tie goes to the requester that did not win last.
  always_comb begin
    w_space  = (r_state == S_IDLE) | out_ready;
    w_accept = ~rst & w_space & (w_elig0 | w_elig1);
    if (w_elig0 & w_elig1) begin
      w_winner = ~r_last;
    end else begin
      w_winner = w_elig1;
    end
  end

  // Handshake and mux select outputs; idle sel shows the previous winner.
  always_comb begin
    ack0 = w_accept & ~w_winner;
    ack1 = w_accept &  w_winner;
    sel  = w_accept ? w_winner : r_last;
  end

  // Output-register FSM: capture the winning word, hold it until drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_out_data <= '0;
      r_out_src  <= 1'b0;
      r_last     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (out_ready && !w_accept) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_accept) begin
        r_out_data <= w_winner ? data1 : data0;
        r_out_src  <= w_winner;
        r_last     <= w_winner;
      end
    end
  end

  // Per-requester grant counters, wrapping modulo 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (ack0) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (ack1) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  assign out_valid   = (r_state == S_FULL);
  assign out_data    = r_out_data;
  assign out_src     = r_out_src;
  assign gnt_cnt0    = r_cnt0;
  assign gnt_cnt1    = r_cnt1;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Bench for mux_arbiter_2to1: directed vectors with literal expectations
// plus a per-cycle comparison against a queue-based behavioural model.
module tb_mux_arbiter_2to1;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  localparam int CMOD  = 2 ** CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0;
  logic [WIDTH-1:0] data0 = '0;
  logic             ack0;
  logic             req1 = 1'b0;
  logic [WIDTH-1:0] data1 = '0;
  logic             ack1;
  logic             lock = 1'b0;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;
  logic             dbg_state;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mux_arbiter_2to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .lock(lock), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The output register is a queue holding {src, data}; at most one entry.
  logic [WIDTH:0] exp_q[$];
  int m_last  = 1;
  int m_cnt0  = 0;
  int m_cnt1  = 0;
  int m_owner = 0;

  // Who (if anyone) gets a word this cycle, from the arbitration rules.
  function automatic void model_pick(output bit acc, output int win);
    bit can0, can1, room;
    room = (exp_q.size() == 0) || out_ready;
    can0 = req0;
    can1 = req1;
`ifdef ARB_LOCK_EN
    if (m_owner != 0) begin
      can0 = req0 && (m_last == 0);
      can1 = req1 && (m_last == 1);
    end
`endif
    acc = !rst && room && (can0 || can1);
    if (can0 && can1) win = 1 - m_last;
    else              win = can1 ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    bit acc;
    int win;
    if (rst) begin
      exp_q.delete();
      m_last = 1; m_cnt0 = 0; m_cnt1 = 0; m_owner = 0;
    end else begin
      model_pick(acc, win);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(win == 1 ? {1'b1, data1} : {1'b0, data0});
        m_last = win;
        if (win == 1) m_cnt1 = (m_cnt1 + 1) % CMOD;
        else          m_cnt0 = (m_cnt0 + 1) % CMOD;
        m_owner = lock ? 1 : 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit acc;
    int win;
    if (chk_en) begin
      model_pick(acc, win);
      chk("m_ack0", 32'(ack0), 32'(acc && win == 0));
      chk("m_ack1", 32'(ack1), 32'(acc && win == 1));
      chk("m_sel", 32'(sel), 32'(acc ? win : m_last));
      chk("m_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("m_state", 32'(dbg_state), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("m_data", 32'(out_data), 32'(exp_q[0][WIDTH-1:0]));
        chk("m_src", 32'(out_src), 32'(exp_q[0][WIDTH]));
      end
      chk("m_cnt0", 32'(gnt_cnt0), 32'(m_cnt0));
      chk("m_cnt1", 32'(gnt_cnt1), 32'(m_cnt1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] pat [8];
  logic [2:0] p;
  bit a0, a1;
  int exp_w [6];

  initial begin
    pat = '{3'b111, 3'b101, 3'b010, 3'b110, 3'b011, 3'b100, 3'b111, 3'b001};
    exp_w = '{0, 1, 0, 1, 0, 1};

    // 1: reset, idle
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_ack0", 32'(ack0), 32'd0);
    chk("t1_ack1", 32'(ack1), 32'd0);
    chk("t1_sel_last", 32'(sel), 32'd1);
    chk("t1_cnt0", 32'(gnt_cnt0), 32'd0);
    chk("t1_cnt1", 32'(gnt_cnt1), 32'd0);

    // 2: single word from requester 0
    tick();
    req0 = 1'b1; data0 = 16'hA5A5; out_ready = 1'b1;
    @(negedge clk);
    chk("t2_ack0", 32'(ack0), 32'd1);
    chk("t2_sel", 32'(sel), 32'd0);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'hA5A5);
    chk("t2_src", 32'(out_src), 32'd0);
    tick();
    @(negedge clk);
    chk("t2_drained", 32'(out_valid), 32'd0);

    // 3: both requesters held, alternating grants
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h0C0C; data1 = 16'h1D1D; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_ack1", 32'(ack1), 32'(exp_w[i]));
      chk("t3_ack0", 32'(ack0), 32'(1 - exp_w[i]));
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("t3_cnt0", 32'(gnt_cnt0), 32'd3);
    chk("t3_cnt1", 32'(gnt_cnt1), 32'd3);
    chk("t3_last_src", 32'(out_src), 32'd1);

    // 4: backpressure holds the word; release grants req1 same cycle
    do_reset();
    req0 = 1'b1; data0 = 16'h1234; out_ready = 1'b0;
    tick();
    req0 = 1'b0; req1 = 1'b1; data1 = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_data", 32'(out_data), 32'h1234);
      chk("t4_hold_ack1", 32'(ack1), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_ack1", 32'(ack1), 32'd1);
    tick();
    req1 = 1'b0;
    @(negedge clk);
    chk("t4_data", 32'(out_data), 32'hBEEF);
    chk("t4_src", 32'(out_src), 32'd1);

    // 5: counter wrap and reset while FULL
    do_reset();
    req0 = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      data0 = 16'(i);
      if (i == 255) begin
        @(negedge clk);
        chk("t5_cnt255", 32'(gnt_cnt0), 32'd255);
      end
      tick();
    end
    req0 = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t5_wrap", 32'(gnt_cnt0), 32'd0);
    chk("t5_full", 32'(out_valid), 32'd1);
    chk("t5_lastword", 32'(out_data), 32'h00FF);
    do_reset();
    @(negedge clk);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);

    // mixed traffic with ready toggling; requesters hold until acked
    do_reset();
    for (int i = 0; i < 40; i++) begin
      p = pat[i % 8];
      if (!req0 && p[2]) begin req0 = 1'b1; data0 = 16'h1000 + 16'(i); end
      if (!req1 && p[1]) begin req1 = 1'b1; data1 = 16'h2000 + 16'(i); end
      out_ready = p[0];
      @(negedge clk);
      a0 = ack0; a1 = ack1;
      tick();
      if (a0) req0 = 1'b0;
      if (a1) req1 = 1'b0;
    end

`ifdef ARB_LOCK_EN
    // 6: lock pins the grant to requester 0
    do_reset();
    lock = 1'b1; req0 = 1'b1; data0 = 16'h0606; out_ready = 1'b1;
    @(negedge clk);
    chk("t6_first", 32'(ack0), 32'd1);
    tick();
    req1 = 1'b1; data1 = 16'h1616;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_lock_ack0", 32'(ack0), 32'd1);
      chk("t6_lock_ack1", 32'(ack1), 32'd0);
      tick();
    end
    lock = 1'b0;
    @(negedge clk);
    chk("t6_unlock_ack0", 32'(ack0), 32'd1);
    tick();
    @(negedge clk);
    chk("t6_req1_wins", 32'(ack1), 32'd1);
    tick();
    req0 = 1'b0; req1 = 1'b0;
`endif

    tick();
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
